// File: rtl/c0_timer_intc_pkg.sv
// Shared CP0 constants and address decode for the Count/Compare timer and interrupt logic.
// Optional build macro C0_INT_SYNC_EN is consumed by c0_timer_intc.
package c0_timer_intc_pkg;

  localparam logic [7:0] CR_COUNT   = 8'h09;
  localparam logic [7:0] CR_COMPARE = 8'h0b;
  localparam logic [7:0] CR_CAUSE   = 8'h0d;
  localparam logic [4:0] EX_INT     = 5'h00;

  typedef enum logic [1:0] {
    SelNone,
    SelCount,
    SelCompare
  } c0_sel_e;

  function automatic c0_sel_e c0_decode(input logic [7:0] addr);
    c0_sel_e sel;
    case (addr)
      CR_COUNT:   sel = SelCount;
      CR_COMPARE: sel = SelCompare;
      default:    sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/c0_int_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous interrupt lines.
// Synchronous active-high reset clears both stages.
module c0_int_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/c0_timer_intc.sv
// CP0 Count/Compare timer, Cause.TI/IP[7:2] and registered interrupt request for WB.
// Define C0_INT_SYNC_EN to pass ext_int_in through a 2-flop synchronizer first.
module c0_timer_intc
  import c0_timer_intc_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned TICK_DIV   = 2,
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned TIMER_IP   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mtc0_we,
  input  logic [7:0]            c0_waddr,
  input  logic [31:0]           c0_wdata,
  input  logic [7:0]            c0_raddr,
  output logic [31:0]           c0_rdata,
  input  logic [7:0]            status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic [1:0]            sw_ip,
  input  logic [NUM_HW_INT-1:0] ext_int_in,
  output logic                  cause_ti,
  output logic [7:0]            cause_ip,
  output logic                  int_req
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam int unsigned TI_BIT = TIMER_IP - 2;

  logic [COUNT_W-1:0]    count_q, count_d;
  logic [COUNT_W-1:0]    compare_q, compare_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  ti_q, ti_d;
  logic [5:0]            ip_hw_q, ip_hw_d;
  logic                  int_req_q, int_req_d;
  logic [NUM_HW_INT-1:0] ext_s;
  logic [5:0]            timer_mask;
  logic                  count_we, compare_we, tick;

`ifdef C0_INT_SYNC_EN
  c0_int_sync #(
    .WIDTH (NUM_HW_INT)
  ) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_int_in),
    .q   (ext_s)
  );
`else
  assign ext_s = ext_int_in;
`endif

  assign count_we   = mtc0_we && (c0_decode(c0_waddr) == SelCount);
  assign compare_we = mtc0_we && (c0_decode(c0_waddr) == SelCompare);
  assign tick       = (pre_q == PRE_MAX);

  // A Count write restarts the prescaler and overrides a same-cycle tick.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    if (count_we) begin
      count_d = c0_wdata[COUNT_W-1:0];
      pre_d   = '0;
    end else if (tick) begin
      count_d = count_q + COUNT_W'(1);
      pre_d   = '0;
    end else begin
      pre_d   = pre_q + PRE_W'(1);
    end
  end

  // Compare write clears TI even when the registered values match this cycle.
  always_comb begin
    compare_d = compare_q;
    ti_d      = ti_q;
    if (compare_we) begin
      compare_d = c0_wdata[COUNT_W-1:0];
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end
  end

  always_comb begin
    ip_hw_d = '0;
    for (int k = 0; k < int'(NUM_HW_INT); k++) begin
      ip_hw_d[k] = ext_s[k];
    end
  end

  always_comb begin
    timer_mask         = '0;
    timer_mask[TI_BIT] = ti_q;
  end

  assign cause_ip  = {ip_hw_q | timer_mask, sw_ip};
  assign cause_ti  = ti_q;
  assign int_req_d = (|(cause_ip & status_im)) & status_ie & ~status_exl;
  assign int_req   = int_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      pre_q     <= '0;
      ti_q      <= 1'b0;
      ip_hw_q   <= '0;
      int_req_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pre_q     <= pre_d;
      ti_q      <= ti_d;
      ip_hw_q   <= ip_hw_d;
      int_req_q <= int_req_d;
    end
  end

  // MFC0 sees the pre-write value since reads come straight off the registers.
  always_comb begin
    c0_rdata = '0;
    case (c0_decode(c0_raddr))
      SelCount:   c0_rdata[COUNT_W-1:0] = count_q;
      SelCompare: c0_rdata[COUNT_W-1:0] = compare_q;
      default:    c0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_c0_timer_intc.sv
// Directed plus randomized bench for c0_timer_intc against an arithmetic reference model.
// Honours C0_INT_SYNC_EN for the expected interrupt latency.
module tb_c0_timer_intc;

  localparam int TICK_DIV = 2;
  localparam int TIMER_IP = 7;
`ifdef C0_INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam logic [7:0] A_CNT = 8'h09;
  localparam logic [7:0] A_CMP = 8'h0b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mtc0_we = 1'b0;
  logic [7:0]  c0_waddr = '0;
  logic [31:0] c0_wdata = '0;
  logic [7:0]  c0_raddr = '0;
  logic [31:0] c0_rdata;
  logic [7:0]  status_im = '0;
  logic        status_ie = 1'b0;
  logic        status_exl = 1'b0;
  logic [1:0]  sw_ip = '0;
  logic [5:0]  ext_int_in = '0;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic        int_req;

  int total = 0;
  int bad = 0;

  // Count is modelled as base + elapsed_cycles / TICK_DIV.
  logic [31:0] m_base = '0;
  int          m_elapsed = 0;
  logic [31:0] m_cmp = '0;
  logic        m_ti = 1'b0;
  logic [5:0]  m_ip = '0;
  logic [5:0]  m_s1 = '0, m_s2 = '0;
  logic        m_req = 1'b0;

  c0_timer_intc #(
    .COUNT_W    (32),
    .TICK_DIV   (TICK_DIV),
    .NUM_HW_INT (6),
    .TIMER_IP   (TIMER_IP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mtc0_we    (mtc0_we),
    .c0_waddr   (c0_waddr),
    .c0_wdata   (c0_wdata),
    .c0_raddr   (c0_raddr),
    .c0_rdata   (c0_rdata),
    .status_im  (status_im),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .sw_ip      (sw_ip),
    .ext_int_in (ext_int_in),
    .cause_ti   (cause_ti),
    .cause_ip   (cause_ip),
    .int_req    (int_req)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_elapsed / TICK_DIV);
  endfunction

  function automatic logic [7:0] m_cause();
    logic [5:0] hw;
    hw = m_ip;
    if (m_ti) hw[TIMER_IP-2] = 1'b1;
    return {hw, sw_ip};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [31:0] val);
    c0_raddr = addr;
    #1;
    val = c0_rdata;
  endtask

  task automatic do_edge();
    logic [31:0] cur;
    logic [7:0]  cause;
    @(posedge clk);
    if (rst) begin
      m_base = '0; m_elapsed = 0; m_cmp = '0; m_ti = 1'b0;
      m_ip = '0; m_s1 = '0; m_s2 = '0; m_req = 1'b0;
    end else begin
      cur   = m_count();
      cause = m_cause();
      m_req = (|(cause & status_im)) & status_ie & ~status_exl;
      if (mtc0_we && c0_waddr == A_CMP) m_ti = 1'b0;
      else if (cur == m_cmp) m_ti = 1'b1;
      if (mtc0_we && c0_waddr == A_CMP) m_cmp = c0_wdata;
      if (mtc0_we && c0_waddr == A_CNT) begin
        m_base = c0_wdata;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
`ifdef C0_INT_SYNC_EN
      m_ip = m_s2; m_s2 = m_s1; m_s1 = ext_int_in;
`else
      m_ip = ext_int_in;
`endif
    end
    #1;
  endtask

  task automatic post_checks();
    chk("cause_ti", 32'(cause_ti), 32'(m_ti));
    chk("cause_ip", 32'(cause_ip), 32'(m_cause()));
    chk("int_req", 32'(int_req), 32'(m_req));
  endtask

  // Reads before the edge also cover MFC0-during-MTC0 returning the old value.
  task automatic step();
    logic [31:0] v;
    logic [7:0]  other;
    read_reg(A_CNT, v);
    chk("rd_count", v, m_count());
    read_reg(A_CMP, v);
    chk("rd_compare", v, m_cmp);
    other = 8'($urandom);
    if (other == A_CNT || other == A_CMP) other = 8'h0d;
    read_reg(other, v);
    chk("rd_other", v, 32'h0);
    do_edge();
    post_checks();
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    mtc0_we = 1'b1; c0_waddr = addr; c0_wdata = data;
    step();
    mtc0_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit seen;
    int n;

    // 1: reset state, free-running count, wrap
    rst = 1'b1;
    do_edge(); do_edge();
    post_checks();
    read_reg(A_CNT, v); chk("reset_count", v, 32'h0);
    read_reg(A_CMP, v); chk("reset_compare", v, 32'h0);
    chk("reset_int_req", 32'(int_req), 32'h0);
    rst = 1'b0;
    repeat (20) step();
    read_reg(A_CNT, v); chk("t1_count10", v, 32'd10);
    mtc0(A_CNT, 32'hFFFF_FFFF);
    repeat (2) step();
    read_reg(A_CNT, v); chk("t1_wrap", v, 32'h0);

    // 2: compare match sets ti one cycle after count reaches compare
    mtc0(A_CNT, 32'h0);
    mtc0(A_CMP, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      read_reg(A_CNT, v);
      if (v == 32'd5) seen = 1'b1;
    end
    chk("t2_reached5", 32'(seen), 32'h1);
    step();
    chk("t2_ti", 32'(cause_ti), 32'h1);
    chk("t2_ip7", 32'(cause_ip[7]), 32'h1);
    mtc0(A_CMP, 32'd100);
    chk("t2_ti_clr", 32'(cause_ti), 32'h0);

    // 3: timer interrupt gated by IE/EXL
    mtc0(A_CNT, 32'h0);
    mtc0(A_CMP, 32'h0);
    step();
    chk("t3_ti", 32'(cause_ti), 32'h1);
    status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
    step();
    chk("t3_req", 32'(int_req), 32'h1);
    status_exl = 1'b1;
    step();
    chk("t3_req_exl", 32'(int_req), 32'h0);
    status_exl = 1'b0;
    step();
    status_ie = 1'b0;
    step();
    chk("t3_req_ie0", 32'(int_req), 32'h0);

    // 4: hardware line latency
    mtc0(A_CMP, 32'hFFFF_0000);
    status_im = 8'h04; status_ie = 1'b1;
    step();
    ext_int_in = 6'b000001;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step();
      if (int_req) n = i;
    end
    chk("t4_latency", 32'(n), 32'(LAT));
    chk("t4_cause_ip", 32'(cause_ip), 32'h04);
    ext_int_in = '0; status_im = '0;
    repeat (LAT) step();

    // 5: compare write beats match; count write beats tick
    mtc0(A_CMP, 32'd60);
    mtc0(A_CNT, 32'd60);
    mtc0(A_CMP, 32'd200);
    chk("t5_ti_clear_wins", 32'(cause_ti), 32'h0);
    step();
    chk("t5_ti_stays0", 32'(cause_ti), 32'h0);
    while ((m_elapsed % TICK_DIV) != TICK_DIV - 1) step();
    mtc0(A_CNT, 32'd7);
    read_reg(A_CNT, v); chk("t5_count7", v, 32'd7);

    // 6: reset mid-count, software interrupt
    mtc0(A_CMP, 32'h1234);
    mtc0(A_CNT, 32'h1234);
    step();
    status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
    step();
    chk("t6_req_pre", 32'(int_req), 32'h1);
    rst = 1'b1; mtc0_we = 1'b1; c0_waddr = A_CNT; c0_wdata = 32'h55;
    step();
    rst = 1'b0; mtc0_we = 1'b0;
    read_reg(A_CNT, v); chk("t6_count0", v, 32'h0);
    chk("t6_ti0", 32'(cause_ti), 32'h0);
    chk("t6_req0", 32'(int_req), 32'h0);
    sw_ip = 2'b01; status_im = 8'h01;
    step();
    chk("t6_sw_req", 32'(int_req), 32'h1);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      mtc0_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: c0_waddr = A_CNT;
        1: c0_waddr = A_CMP;
        2: c0_waddr = 8'h0d;
        default: c0_waddr = 8'($urandom);
      endcase
      c0_wdata = ($urandom_range(0, 1) == 0) ? m_count() + 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) ext_int_in = 6'($urandom);
      status_im  = 8'($urandom);
      status_ie  = ($urandom_range(0, 3) != 0);
      status_exl = ($urandom_range(0, 3) == 0);
      sw_ip      = 2'($urandom);
      step();
    end
    rst = 1'b0; mtc0_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
